// File: rtl/pipe_pkg.sv
// Shared types and constants for the reusable pipeline-stage register.
// Stage control fields are packed structs so each boundary can size CTRL_W with $bits.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } pipe_state_e;

  typedef struct packed {
    logic       insn_vld;
    logic [2:0] funct3;
    logic [3:0] alu_op;
    logic [1:0] wb_sel;
    logic       op_a_sel;
    logic       op_b_sel;
    logic       br_un;
    logic       mem_wren;
    logic       mem_ren;
    logic       rd_wren;
  } id_ex_ctrl_t;

  typedef struct packed {
    logic       insn_vld;
    logic [2:0] funct3;
    logic [1:0] wb_sel;
    logic       mem_wren;
    logic       mem_ren;
    logic       rd_wren;
  } ex_mem_ctrl_t;

  localparam int ID_EX_CTRL_W  = $bits(id_ex_ctrl_t);
  localparam int EX_MEM_CTRL_W = $bits(ex_mem_ctrl_t);

  // A bubble in ID/EX must not write anything; br_un defaults to unsigned compare.
  localparam id_ex_ctrl_t  ID_EX_CTRL_RST  = '{br_un: 1'b1, default: '0};
  localparam ex_mem_ctrl_t EX_MEM_CTRL_RST = '{default: '0};

  function automatic logic [1:0] occ_of(input pipe_state_e s);
    case (s)
      ST_ONE:  return 2'd1;
      ST_TWO:  return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_skid_stage_if.sv
// Handshake and payload bundle between two pipeline stages.
// The slave modport is the stage register; the master is whoever drives it.
interface pipe_skid_stage_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16
);
  logic              i_flush;
  logic              i_valid;
  logic              o_ready;
  logic [DATA_W-1:0] i_data;
  logic [CTRL_W-1:0] i_ctrl;
  logic              o_valid;
  logic              i_ready;
  logic [DATA_W-1:0] o_data;
  logic [CTRL_W-1:0] o_ctrl;
  logic [1:0]        o_occ;

  modport master (
    output i_flush, i_valid, i_data, i_ctrl, i_ready,
    input  o_ready, o_valid, o_data, o_ctrl, o_occ
  );

  modport slave (
    input  i_flush, i_valid, i_data, i_ctrl, i_ready,
    output o_ready, o_valid, o_data, o_ctrl, o_occ
  );
endinterface

// File: rtl/pipe_skid_stage.sv
// Pipeline-stage register with valid/ready handshake and a two-entry skid buffer.
// o_ready is a flop so backpressure never chains combinationally across stages.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int                DATA_W        = 32,
  parameter int                CTRL_W        = 16,
  parameter logic [CTRL_W-1:0] CTRL_RST      = '0,
  parameter bit                ZERO_ON_FLUSH = 1'b1
) (
  input logic              i_clk,
  input logic              i_reset,
  pipe_skid_stage_if.slave bus
);

  pipe_state_e       state_reg, state_next;
  logic              ready_reg, ready_next;
  logic [DATA_W-1:0] main_data_reg, main_data_next;
  logic [CTRL_W-1:0] main_ctrl_reg, main_ctrl_next;
  logic [DATA_W-1:0] skid_data_reg, skid_data_next;
  logic [CTRL_W-1:0] skid_ctrl_reg, skid_ctrl_next;

  logic acc;
  logic take;
  logic valid_out;

  assign valid_out = (state_reg != ST_EMPTY);
  assign acc       = bus.i_valid & ready_reg;
  assign take      = valid_out & bus.i_ready;

  always_comb begin
    state_next     = state_reg;
    main_data_next = main_data_reg;
    main_ctrl_next = main_ctrl_reg;
    skid_data_next = skid_data_reg;
    skid_ctrl_next = skid_ctrl_reg;

    case (state_reg)
      ST_EMPTY: begin
        if (acc) begin
          state_next     = ST_ONE;
          main_data_next = bus.i_data;
          main_ctrl_next = bus.i_ctrl;
        end
      end
      ST_ONE: begin
        if (acc && take) begin
          main_data_next = bus.i_data;
          main_ctrl_next = bus.i_ctrl;
        end else if (acc) begin
          state_next     = ST_TWO;
          skid_data_next = bus.i_data;
          skid_ctrl_next = bus.i_ctrl;
        end else if (take) begin
          // Going empty: drop the control word so no stale enable leaks out.
          state_next     = ST_EMPTY;
          main_ctrl_next = CTRL_RST;
        end
      end
      ST_TWO: begin
        if (take) begin
          state_next     = ST_ONE;
          main_data_next = skid_data_reg;
          main_ctrl_next = skid_ctrl_reg;
          skid_ctrl_next = CTRL_RST;
        end
      end
      default: begin
        state_next     = ST_EMPTY;
        main_ctrl_next = CTRL_RST;
        skid_ctrl_next = CTRL_RST;
      end
    endcase

    // Flush overrides every handshake outcome; the beat offered this cycle is lost.
    if (bus.i_flush) begin
      state_next     = ST_EMPTY;
      main_ctrl_next = CTRL_RST;
      skid_ctrl_next = CTRL_RST;
      if (ZERO_ON_FLUSH) begin
        main_data_next = '0;
        skid_data_next = '0;
      end else begin
        main_data_next = main_data_reg;
        skid_data_next = skid_data_reg;
      end
    end

    ready_next = (state_next != ST_TWO);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg     <= ST_EMPTY;
      ready_reg     <= 1'b1;
      main_ctrl_reg <= CTRL_RST;
      skid_ctrl_reg <= CTRL_RST;
      if (ZERO_ON_FLUSH) begin
        main_data_reg <= '0;
        skid_data_reg <= '0;
      end
    end else begin
      state_reg     <= state_next;
      ready_reg     <= ready_next;
      main_data_reg <= main_data_next;
      main_ctrl_reg <= main_ctrl_next;
      skid_data_reg <= skid_data_next;
      skid_ctrl_reg <= skid_ctrl_next;
    end
  end

  assign bus.o_ready = ready_reg;
  assign bus.o_valid = valid_out;
  assign bus.o_data  = main_data_reg;
  assign bus.o_ctrl  = main_ctrl_reg;
  assign bus.o_occ   = occ_of(state_reg);

endmodule

// File: doc/pipe_skid_stage.md
# pipe_skid_stage

Parametrised pipeline-stage register that replaces the hand-written per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one reusable block. It carries a generic data payload plus a separately reset control field. Unlike a plain flop stage, it adds a valid/ready handshake so the hazard unit can stall a stage without losing an instruction. A two-entry skid buffer keeps `o_ready` registered, so backpressure never forms a combinational path across stages. Flush still has priority and inserts a bubble with defined control values.

## Interface
Parameters:
- `DATA_W`, default 32: width of the data payload (pc, operands, immediate, instruction, addresses) packed by the instantiating stage.
- `CTRL_W`, default 16: width of the control field (rd_wren, mem_ren, mem_wren, alu_op, sel bits, insn_vld, …).
- `CTRL_RST`, default `'0`: value `o_ctrl` takes on reset and flush (e.g. a br_un bit = 1).
- `ZERO_ON_FLUSH`, default 1: 1 clears both data registers on reset/flush; 0 leaves the data registers untouched.

Ports:
- `i_clk` in 1: clock, rising edge.
- `i_reset` in 1: reset, synchronous, active-high.
- `i_flush` in 1: synchronous flush; empties the stage.
- `i_valid` in 1: upstream has a valid instruction.
- `o_ready` out 1: stage can accept; registered.
- `i_data` in DATA_W: upstream payload.
- `i_ctrl` in CTRL_W: upstream control field.
- `o_valid` out 1: the stage holds a valid instruction.
- `i_ready` in 1: downstream accepts this cycle.
- `o_data` out DATA_W: main-register payload.
- `o_ctrl` out CTRL_W: main-register control; equals CTRL_RST when `o_valid`=0.
- `o_occ` out 2: occupancy, 0/1/2 (debug and performance counters).

## Operation
- The upstream transfer is `acc = i_valid & o_ready`. The downstream transfer is `take = o_valid & i_ready`.
- Storage consists of a main register (drives the outputs) and a skid register. The state is `ST_EMPTY`, `ST_ONE` or `ST_TWO`.
- Transitions from `ST_EMPTY`:
  - `acc` → `ST_ONE`, and the main register loads the input.
  - Otherwise stay in `ST_EMPTY`.
- Transitions from `ST_ONE`:
  - `acc & take` → `ST_ONE`, and the main register loads the input.
  - `acc & !take` → `ST_TWO`, and the skid register loads the input.
  - `!acc & take` → `ST_EMPTY`.
  - Neither → hold.
- Transitions from `ST_TWO`:
  - `take` → `ST_ONE`, and the main register loads from the skid register.
  - Otherwise hold.
  - `acc` is impossible here because `o_ready`=0.
- `o_ready` is registered: it is 1 in every state except `ST_TWO`, computed from the next state.
- Flush:
  - The next state is `ST_EMPTY` regardless of `acc` or `take`.
  - Input presented in the flush cycle is dropped.
  - `o_ctrl` and the skid control field take CTRL_RST.
  - The data registers take 0 when ZERO_ON_FLUSH=1.
- Priority order: `i_reset` > `i_flush` > handshake.
- Whenever `o_valid`=0, `o_ctrl` equals CTRL_RST, so downstream never sees a stale write enable.
- Stability: while `o_valid & !i_ready`, `o_data` and `o_ctrl` must not change.
- Order is preserved (FIFO); no payload is duplicated or lost except by flush.

## Timing
- Reset values: `o_valid`=0, `o_ready`=1, `o_occ`=0, `o_ctrl`=CTRL_RST, `o_data`=0, state `ST_EMPTY`.
- Latency: an accept at edge N appears on `o_data`/`o_valid` after edge N, usable in cycle N+1.
- Throughput: 1 transfer per cycle when `i_ready` is held at 1.
- After `i_ready` drops, the stage absorbs exactly one more upstream beat. `o_ready` goes to 0 one cycle later.
- After flush: `o_valid`=0 and `o_ready`=1 in the next cycle.
- Flush and take in the same cycle: downstream consumes the current output, and the stage then empties.
- Reset asserted mid-stall: the stage is empty the next cycle; no output state survives.

## Structure
- Shared package `pipe_pkg` holds:
  - typedef `pipe_state_e` with values `ST_EMPTY`, `ST_ONE`, `ST_TWO`;
  - packed-struct typedefs `id_ex_ctrl_t` and `ex_mem_ctrl_t`, whose `$bits` feeds CTRL_W;
  - constant `ID_EX_CTRL_RST`.
- Single module, no sub-module. Each pipeline boundary instantiates it once, packing its fields into `i_data`/`i_ctrl`.

## Test plan
- **Streaming:** 8 beats, data 0x100..0x107, `i_ready`=1 throughout → outputs 0x100..0x107 on consecutive cycles, one cycle behind, `o_ready` constantly 1.
- **Backpressure:** during streaming, `i_ready`=0 for 3 cycles.
  - Required response: one extra beat is absorbed, `o_occ`=2, `o_ready`=0 the following cycle, `o_data` stable.
  - When `i_ready` returns: order is preserved and there are no gaps.
- **Flush while full:** `o_occ`=2 with data 0xA/0xB, assert `i_flush` with `i_valid`=1 and data 0xC.
  - Next cycle: `o_valid`=0, `o_occ`=0, `o_ctrl`=CTRL_RST, `o_data`=0.
  - 0xC never appears.
- **Flush with take:** `o_occ`=1 with data 0x55, `i_ready`=1 and `i_flush`=1 together → 0x55 counted as consumed once, stage empty the next cycle.
- **Reset mid-stall:** `o_occ`=2, `i_reset`=1 for 1 cycle → all outputs at their reset values the next cycle; fresh data 0x1 then passes with latency 1.
- **Control reset value:** CTRL_RST=0x0001, ZERO_ON_FLUSH=0, flush with data 0xDEAD held → `o_ctrl`=0x0001 and `o_data` still 0xDEAD.
